// File: rtl/bus_mem_adapter_pkg.sv
// Types and constants for the TL-UL to req/gnt/rvalid memory adapter.
package bus_mem_adapter_pkg;
  import bus_params_pkg::*;

  typedef enum logic [2:0] {
    PutFullData    = 3'd0,
    PutPartialData = 3'd1,
    Get            = 3'd4
  } a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'd0,
    AccessAckData = 3'd1
  } d_op_e;

  // One entry per accepted A request, retired on the matching D handshake.
  typedef struct packed {
    logic               is_get;
    logic [BUS_SZW-1:0] size;
    logic [BUS_AIW-1:0] source;
    logic               err;
  } track_entry_t;

  localparam int TrackW = $bits(track_entry_t);
  localparam logic [BUS_DW-1:0] DataMax = '1;
endpackage

// File: rtl/bus_params_pkg.sv
// Bus geometry shared by the crossbar-side agents and the device adapters.
package bus_params_pkg;
  localparam int BUS_AW  = 32;
  localparam int BUS_DW  = 32;
  localparam int BUS_DBW = BUS_DW / 8;
  localparam int BUS_SZW = 2;
  localparam int BUS_AIW = 8;
endpackage

// File: rtl/bus_mem_adapter_fifo.sv
// Synchronous FIFO without fall-through: full/empty reflect occupancy before
// this cycle's push/pop, and a push while full is ignored even if a pop happens.
module bus_mem_adapter_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  always_comb begin
    full_o   = (cnt_q == DepthCnt);
    empty_o  = (cnt_q == '0);
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    rdata_o  = mem_q[rd_ptr_q];
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/bus_mem_adapter.sv
// Device-side TL-UL adapter onto a req/gnt/rvalid memory port with in-order D responses.
// Define BUS_MEM_ADAPTER_ERR_EN to reject malformed requests locally with an error response.
module bus_mem_adapter
  import bus_mem_adapter_pkg::*;
#(
  parameter int AW          = bus_params_pkg::BUS_AW,
  parameter int DW          = bus_params_pkg::BUS_DW,
  parameter int DBW         = bus_params_pkg::BUS_DBW,
  parameter int SZW         = bus_params_pkg::BUS_SZW,
  parameter int AIW         = bus_params_pkg::BUS_AIW,
  parameter int Outstanding = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           a_valid_i,
  output logic           a_ready_o,
  input  logic [2:0]     a_opcode_i,
  input  logic [SZW-1:0] a_size_i,
  input  logic [DBW-1:0] a_mask_i,
  input  logic [AW-1:0]  a_address_i,
  input  logic [AIW-1:0] a_source_i,
  input  logic [DW-1:0]  a_data_i,
  output logic           d_valid_o,
  input  logic           d_ready_i,
  output logic [2:0]     d_opcode_o,
  output logic [SZW-1:0] d_size_o,
  output logic [AIW-1:0] d_source_o,
  output logic [DW-1:0]  d_data_o,
  output logic           d_error_o,
  output logic           mem_req_o,
  input  logic           mem_gnt_i,
  output logic           mem_we_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic [DW-1:0]  mem_wdata_o,
  output logic [DBW-1:0] mem_wmask_o,
  input  logic           mem_rvalid_i,
  input  logic [DW-1:0]  mem_rdata_i
);
  localparam int LowW  = $clog2(DBW);
  localparam int PendW = $clog2(Outstanding + 1);

  logic              err_now;
  logic              a_hs, mem_hs, d_hs, rsp_push;
  logic              track_full, track_empty, rsp_full, rsp_empty;
  track_entry_t      track_wdata, track_head;
  logic [TrackW-1:0] track_rdata;
  logic [DW-1:0]     rsp_rdata;
  logic [PendW-1:0]  mem_pend_q, mem_pend_d;

`ifdef BUS_MEM_ADAPTER_ERR_EN
  int unsigned     nbytes;
  logic [LowW-1:0] off, amask;
  logic [DBW-1:0]  exp_mask;

  always_comb begin
    nbytes   = 32'd1 << a_size_i;
    off      = a_address_i[LowW-1:0];
    amask    = LowW'(nbytes - 32'd1);
    exp_mask = '0;
    for (int b = 0; b < DBW; b++) begin
      exp_mask[b] = (b >= int'(off)) && (b < int'(off) + int'(nbytes));
    end
    err_now = !(a_opcode_i inside {PutFullData, PutPartialData, Get})
            | (a_size_i > SZW'(LowW))
            | ((off & amask) != '0)
            | ((a_opcode_i == PutFullData) & (a_mask_i != exp_mask));
  end
`else
  assign err_now = 1'b0;
`endif

  // Valid/ready: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and the payload is only meaningful with valid.
  always_comb begin
    mem_req_o   = a_valid_i & ~track_full & ~err_now;
    a_ready_o   = ~track_full & (mem_gnt_i | err_now);
    a_hs        = a_valid_i & a_ready_o;
    mem_hs      = mem_req_o & mem_gnt_i;
    mem_we_o    = (a_opcode_i != Get);
    mem_addr_o  = {a_address_i[AW-1:LowW], LowW'(0)};
    mem_wdata_o = a_data_i;
    mem_wmask_o = a_mask_i;

    track_wdata.is_get = (a_opcode_i == Get);
    track_wdata.size   = a_size_i;
    track_wdata.source = a_source_i;
    track_wdata.err    = err_now;
    track_head         = track_entry_t'(track_rdata);

    // Returns arriving with nothing pending belong to requests wiped by a reset.
    rsp_push = mem_rvalid_i & (mem_pend_q != '0);
    case ({mem_hs, rsp_push})
      2'b10:   mem_pend_d = mem_pend_q + PendW'(1);
      2'b01:   mem_pend_d = mem_pend_q - PendW'(1);
      default: mem_pend_d = mem_pend_q;
    endcase

    d_valid_o  = ~track_empty & (track_head.err | ~rsp_empty);
    d_hs       = d_valid_o & d_ready_i;
    d_opcode_o = AccessAck;
    d_size_o   = '0;
    d_source_o = '0;
    d_data_o   = '0;
    d_error_o  = 1'b0;
    if (d_valid_o) begin
      d_opcode_o = track_head.is_get ? AccessAckData : AccessAck;
      d_size_o   = track_head.size;
      d_source_o = track_head.source;
      if (track_head.is_get) d_data_o = track_head.err ? DataMax : rsp_rdata;
`ifdef BUS_MEM_ADAPTER_ERR_EN
      d_error_o  = track_head.err;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) mem_pend_q <= '0;
    else         mem_pend_q <= mem_pend_d;
  end

  bus_mem_adapter_fifo #(.Width(TrackW), .Depth(Outstanding)) u_track_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (a_hs),
    .wdata_i (track_wdata),
    .pop_i   (d_hs),
    .rdata_o (track_rdata),
    .full_o  (track_full),
    .empty_o (track_empty)
  );

  // Errored entries never reach memory, so they own no response slot.
  bus_mem_adapter_fifo #(.Width(DW), .Depth(Outstanding)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (rsp_push),
    .wdata_i (mem_rdata_i),
    .pop_i   (d_hs & ~track_head.err),
    .rdata_o (rsp_rdata),
    .full_o  (rsp_full),
    .empty_o (rsp_empty)
  );

  logic unused_rsp_full;
  assign unused_rsp_full = rsp_full;
endmodule

// File: tb/tb_bus_mem_adapter.sv
// Directed and randomized checks of bus_mem_adapter against a word-memory reference model.
module tb_bus_mem_adapter;
  localparam int OUTS = 2;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        a_valid_i = 1'b0;
  logic        a_ready_o;
  logic [2:0]  a_opcode_i = '0;
  logic [1:0]  a_size_i = '0;
  logic [3:0]  a_mask_i = '0;
  logic [31:0] a_address_i = '0;
  logic [7:0]  a_source_i = '0;
  logic [31:0] a_data_i = '0;
  logic        d_valid_o;
  logic        d_ready_i = 1'b0;
  logic [2:0]  d_opcode_o;
  logic [1:0]  d_size_o;
  logic [7:0]  d_source_o;
  logic [31:0] d_data_o;
  logic        d_error_o;
  logic        mem_req_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gnt_mode = 0;
  int dly_min = 1;
  int dly_max = 3;
  bit d_rand = 0;

  logic [31:0] ref_mem [16];
  logic [31:0] slave_mem [16];
  logic [45:0] exp_q [$];
  logic [31:0] sq_data [$];
  int          sq_due [$];
  bit          hold = 0;
  logic [45:0] held = '0;
  logic        s_req, s_we;
  logic [3:0]  s_wmask;
  logic [31:0] s_addr;

  bus_mem_adapter dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_opcode_i(a_opcode_i),
    .a_size_i(a_size_i), .a_mask_i(a_mask_i), .a_address_i(a_address_i),
    .a_source_i(a_source_i), .a_data_i(a_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_opcode_o(d_opcode_o),
    .d_size_o(d_size_o), .d_source_o(d_source_o), .d_data_o(d_data_o),
    .d_error_o(d_error_o),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  // Clock and reset-independent cycle counter
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [45:0] d_fields();
    return {d_error_o, d_opcode_o, d_size_o, d_source_o, d_data_o};
  endfunction

  function automatic logic ref_err();
`ifdef BUS_MEM_ADAPTER_ERR_EN
    int nb;
    int exp_m;
    if (!(a_opcode_i == 3'd0 || a_opcode_i == 3'd1 || a_opcode_i == 3'd4)) return 1'b1;
    if (a_size_i > 2'd2) return 1'b1;
    nb = 1 << a_size_i;
    if ((a_address_i % nb) != 0) return 1'b1;
    exp_m = ((1 << nb) - 1) << (a_address_i % 4);
    if (a_opcode_i == 3'd0 && int'(a_mask_i) != exp_m) return 1'b1;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // Memory slave: grant policy plus in-order returns after a programmable delay
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    case (gnt_mode)
      0:       mem_gnt_i = 1'b0;
      1:       mem_gnt_i = 1'b1;
      default: mem_gnt_i = 1'($urandom_range(0, 1));
    endcase
    if (sq_due.size() != 0 && sq_due[0] <= cyc) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = sq_data.pop_front();
      void'(sq_due.pop_front());
    end else begin
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    if (d_rand) d_ready_i = 1'($urandom_range(0, 1));
  end

  // Scoreboard: reference model of outstanding requests, memory contents and D stability
  always @(negedge clk) begin
    logic [45:0] f;
    logic [45:0] rec;
    logic        e, get;
    logic [31:0] rd;
    if (!rst_ni) begin
      exp_q.delete();
      hold = 0;
    end else begin
      f = d_fields();
      e = ref_err();
      chk("mem_req", mem_req_o, a_valid_i && exp_q.size() < OUTS && !e);
      chk("a_ready", a_ready_o, exp_q.size() < OUTS && (mem_gnt_i || e));
      if (hold) begin
        chk("d_hold_valid", d_valid_o, 1'b1);
        chk("d_hold_fields", f, held);
      end
      if (exp_q.size() == 0) chk("d_idle", d_valid_o, 1'b0);
      if (d_valid_o && d_ready_i && exp_q.size() != 0) chk("d_resp", f, exp_q.pop_front());
      if (a_valid_i && a_ready_o) begin
        get = (a_opcode_i == 3'd4);
        rd  = '0;
        if (e) rd = get ? 32'hFFFF_FFFF : 32'h0;
        else if (get) rd = ref_mem[a_address_i[5:2]];
        else for (int b = 0; b < 4; b++)
          if (a_mask_i[b]) ref_mem[a_address_i[5:2]][8*b +: 8] = a_data_i[8*b +: 8];
        rec = {e, get ? 3'd1 : 3'd0, a_size_i, a_source_i, rd};
        exp_q.push_back(rec);
      end
      if (mem_req_o && mem_gnt_i) begin
        chk("mem_addr", mem_addr_o, a_address_i & ~32'h3);
        chk("mem_we", mem_we_o, a_opcode_i != 3'd4);
        chk("mem_wdata", mem_wdata_o, a_data_i);
        chk("mem_wmask", mem_wmask_o, a_mask_i);
        if (mem_we_o) begin
          for (int b = 0; b < 4; b++)
            if (mem_wmask_o[b]) slave_mem[mem_addr_o[5:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
          sq_data.push_back($urandom);
        end else begin
          sq_data.push_back(slave_mem[mem_addr_o[5:2]]);
        end
        sq_due.push_back(cyc + $urandom_range(dly_min, dly_max));
      end
      hold = d_valid_o && !d_ready_i;
      held = f;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic a_send(input logic [2:0] op, input logic [1:0] sz, input logic [3:0] m,
                        input logic [31:0] addr, input logic [7:0] src, input logic [31:0] dat);
    bit acc = 0;
    a_opcode_i = op; a_size_i = sz; a_mask_i = m;
    a_address_i = addr; a_source_i = src; a_data_i = dat;
    a_valid_i = 1'b1;
    for (int i = 0; i < 60 && !acc; i++) begin
      @(negedge clk);
      if (a_ready_o) begin
        acc = 1; s_req = mem_req_o; s_we = mem_we_o; s_wmask = mem_wmask_o; s_addr = mem_addr_o;
      end
      step();
    end
    a_valid_i = 1'b0;
    if (!acc) chk("a_accept_timeout", 0, 1);
  endtask

  task automatic wait_d(input string tag);
    bit got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (d_valid_o) got = 1;
    end
    if (!got) chk(tag, 0, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  r_op;
    logic [1:0]  r_sz;
    logic [3:0]  r_m;
    logic [31:0] r_addr;
    logic [45:0] f0;
    bit          found;
    int          k;

    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      slave_mem[i] = ref_mem[i];
    end
    ref_mem[4] = 32'hDEAD_BEEF;
    slave_mem[4] = 32'hDEAD_BEEF;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ready", a_ready_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_d_valid", d_valid_o, 1'b0);
    chk("rst_d_fields", d_fields(), 46'd0);
    step();
    rst_ni = 1'b1; gnt_mode = 1; d_ready_i = 1'b1; dly_min = 2; dly_max = 2;

    // Get with rvalid two cycles after grant; D exactly one cycle after rvalid
    a_send(3'd4, 2'd2, 4'hF, 32'h10, 8'd3, 32'h0);
    chk("t1_req", s_req, 1'b1);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_rvalid_i) found = 1;
    end
    if (!found) chk("t1_rvalid_timeout", 0, 1);
    chk("t1_d_early", d_valid_o, 1'b0);
    @(negedge clk);
    chk("t1_d_valid", d_valid_o, 1'b1);
    chk("t1_d_opcode", d_opcode_o, 3'd1);
    chk("t1_d_source", d_source_o, 8'd3);
    chk("t1_d_data", d_data_o, 32'hDEAD_BEEF);
    step();

    // PutFullData
    a_send(3'd0, 2'd2, 4'hF, 32'h20, 8'd5, 32'h1234);
    chk("t2_we", s_we, 1'b1);
    chk("t2_wmask", s_wmask, 4'hF);
    chk("t2_addr", s_addr, 32'h20);
    wait_d("t2_d_timeout");
    chk("t2_d_opcode", d_opcode_o, 3'd0);
    chk("t2_d_data", d_data_o, 32'h0);
    step();
    drain();

    // Misaligned Get: rejected locally or forwarded depending on build
    a_send(3'd4, 2'd2, 4'hF, 32'h3, 8'd9, 32'h0);
`ifdef BUS_MEM_ADAPTER_ERR_EN
    chk("err_req", s_req, 1'b0);
    wait_d("err_d_timeout");
    chk("err_d_error", d_error_o, 1'b1);
    chk("err_d_data", d_data_o, 32'hFFFF_FFFF);
`else
    chk("fwd_req", s_req, 1'b1);
    wait_d("fwd_d_timeout");
    chk("fwd_d_error", d_error_o, 1'b0);
`endif
    step();
    drain();

    // Outstanding limit: third Get waits for the first D pop
    dly_min = 1; dly_max = 3; d_ready_i = 1'b0;
    a_send(3'd4, 2'd2, 4'hF, 32'h4, 8'd1, 32'h0);
    a_send(3'd4, 2'd2, 4'hF, 32'h8, 8'd2, 32'h0);
    a_opcode_i = 3'd4; a_size_i = 2'd2; a_mask_i = 4'hF;
    a_address_i = 32'hC; a_source_i = 8'd7; a_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t3_blocked", a_ready_o, 1'b0);
      step();
    end
    d_ready_i = 1'b1;
    @(negedge clk);
    chk("t3_pop_valid", d_valid_o, 1'b1);
    chk("t3_ready_at_pop", a_ready_o, 1'b0);
    step();
    d_ready_i = 1'b0;
    @(negedge clk);
    chk("t3_ready_after_pop", a_ready_o, 1'b1);
    step();
    a_valid_i = 1'b0;

    // D held back five cycles
    wait_d("t4_d_timeout");
    f0 = d_fields();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold", d_fields(), f0);
    end
    step();
    d_ready_i = 1'b1;
    drain();

    // Reset with two reads in flight; late returns must be dropped
    dly_min = 6; dly_max = 6; d_ready_i = 1'b0;
    a_send(3'd4, 2'd2, 4'hF, 32'h0, 8'd4, 32'h0);
    a_send(3'd4, 2'd2, 4'hF, 32'h4, 8'd6, 32'h0);
    rst_ni = 1'b0;
    step();
    @(negedge clk);
    chk("rst_mid_d_valid", d_valid_o, 1'b0);
    step();
    rst_ni = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("stale_d_valid", d_valid_o, 1'b0);
      step();
    end

    // Randomized traffic with random grants, return delays and D back-pressure
    gnt_mode = 2; dly_min = 1; dly_max = 3; d_rand = 1;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 2);
      r_op = (k == 0) ? 3'd0 : (k == 1) ? 3'd1 : 3'd4;
      r_sz = 2'd2;
      r_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      r_m = (r_op == 3'd1) ? 4'($urandom_range(0, 15)) : 4'hF;
`ifdef BUS_MEM_ADAPTER_ERR_EN
      if ($urandom_range(0, 3) == 0) begin
        r_op = 3'($urandom_range(0, 7));
        r_sz = 2'($urandom_range(0, 3));
        r_addr = {26'd0, 6'($urandom_range(0, 63))};
        r_m = 4'($urandom_range(0, 15));
      end
`endif
      a_send(r_op, r_sz, r_m, r_addr, 8'($urandom_range(0, 255)), $urandom);
      repeat ($urandom_range(0, 2)) step();
    end
    d_rand = 0;
    step();
    d_ready_i = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
